// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory read port, issue handshake to the control unit, branch resolution.
// master = fetch unit, slave = memory/control-unit side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [7:0]        imem_rdata;
    logic [7:0]        instr_out;
    logic [7:0]        target_out;
    logic [ADDR_W-1:0] link_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic              br_valid;
    logic              br_taken;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        output instr_out, target_out, link_addr, instr_valid,
        input  instr_ready, br_valid, br_taken,
        output pc_out
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        input  instr_out, target_out, link_addr, instr_valid,
        output instr_ready, br_valid, br_taken,
        input  pc_out
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetches 1/2-byte instructions and resolves J/JAL/BEQ/BNE; issue is valid 2 (1-byte) or 4 (2-byte) cycles
// after fetch start with 1-cycle memory; issued outputs hold while instr_ready=0 and no new fetch starts.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH_OP, FETCH_TGT, ISSUE, WAIT_BR} state_t;

    localparam logic [3:0] OP_J   = 4'b1000;
    localparam logic [3:0] OP_JAL = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [3:0] OP_BNE = 4'b1101;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_link;
    logic              r_req;
    logic              r_valid;
    logic [7:0]        r_instr;
    logic [7:0]        r_target;

    logic [ADDR_W-1:0] w_pc_p1;
    logic [ADDR_W-1:0] w_pc_p2;
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_br_next;
    logic [3:0]        w_op;
    logic [3:0]        w_rd_op;
    logic              w_rd_two;

    assign w_pc_p1   = r_pc + ADDR_W'(1);
    assign w_pc_p2   = r_pc + ADDR_W'(2);
    // Target byte is zero-extended or truncated to the PC width.
    assign w_tgt     = ADDR_W'(r_target);
    assign w_br_next = bus.br_taken ? w_tgt : w_pc_p2;
    assign w_op      = r_instr[7:4];
    assign w_rd_op   = bus.imem_rdata[7:4];
    assign w_rd_two  = (w_rd_op == OP_J) || (w_rd_op == OP_JAL) ||
                       (w_rd_op == OP_BEQ) || (w_rd_op == OP_BNE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= FETCH_OP;
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_instr  <= '0;
            r_target <= '0;
            r_link   <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                FETCH_OP: begin
                    if (!r_req) begin
                        // Only reached straight out of reset; every other entry launches its own request.
                        r_req  <= 1'b1;
                        r_addr <= r_pc;
                    end else if (bus.imem_rvalid) begin
                        r_instr <= bus.imem_rdata;
                        if (w_rd_two) begin
                            r_addr  <= w_pc_p1;
                            r_state <= FETCH_TGT;
                        end else begin
                            r_req    <= 1'b0;
                            r_target <= '0;
                            r_link   <= w_pc_p1;
                            r_valid  <= 1'b1;
                            r_state  <= ISSUE;
                        end
                    end
                end
                FETCH_TGT: begin
                    if (r_req && bus.imem_rvalid) begin
                        r_req    <= 1'b0;
                        r_target <= bus.imem_rdata;
                        r_link   <= w_pc_p2;
                        r_valid  <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        r_valid <= 1'b0;
                        case (w_op)
                            OP_J, OP_JAL: begin
                                r_pc    <= w_tgt;
                                r_req   <= 1'b1;
                                r_addr  <= w_tgt;
                                r_state <= FETCH_OP;
                            end
                            OP_BEQ, OP_BNE: begin
                                r_state <= WAIT_BR;
                            end
                            default: begin
                                r_pc    <= w_pc_p1;
                                r_req   <= 1'b1;
                                r_addr  <= w_pc_p1;
                                r_state <= FETCH_OP;
                            end
                        endcase
                    end
                end
                WAIT_BR: begin
                    if (bus.br_valid) begin
                        r_pc    <= w_br_next;
                        r_req   <= 1'b1;
                        r_addr  <= w_br_next;
                        r_state <= FETCH_OP;
                    end
                end
                default: r_state <= FETCH_OP;
            endcase
        end
    end

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_addr;
    assign bus.instr_out   = r_instr;
    assign bus.target_out  = r_target;
    assign bus.link_addr   = r_link;
    assign bus.instr_valid = r_valid;
    assign bus.pc_out      = r_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: sequential fetch, backpressure, J/JAL, BEQ/BNE, reset mid-fetch, PC wrap (second DUT, RESET_PC=0xFF).
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    instr_fetch_unit_if #(.ADDR_W(8)) ifc ();
    instr_fetch_unit_if #(.ADDR_W(8)) ifc2 ();

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.master)
    );
    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(ifc2.master)
    );

    // Shared single-cycle memory; each port answers once per request.
    logic [7:0] mem [0:255];
    logic       rv1, rv2, man_en, man_rv;
    logic [7:0] rd1, rd2, man_rd;

    always @(posedge clk) begin
        if (!rst_n) rv1 <= 1'b0;
        else if (ifc.imem_req && !rv1) begin
            rv1 <= 1'b1;
            rd1 <= mem[ifc.imem_addr];
        end else rv1 <= 1'b0;
    end
    always @(posedge clk) begin
        if (!rst2_n) rv2 <= 1'b0;
        else if (ifc2.imem_req && !rv2) begin
            rv2 <= 1'b1;
            rd2 <= mem[ifc2.imem_addr];
        end else rv2 <= 1'b0;
    end
    assign ifc.imem_rvalid  = man_en ? man_rv : rv1;
    assign ifc.imem_rdata   = man_en ? man_rd : rd1;
    assign ifc2.imem_rvalid = rv2;
    assign ifc2.imem_rdata  = rd2;

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!ifc.instr_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_valid2(output int cnt);
        cnt = 0;
        while (!ifc2.instr_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic accept;
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        ifc.instr_ready = 1'b0;
    endtask

    task automatic accept2;
        ifc2.instr_ready = 1'b1;
        @(negedge clk);
        ifc2.instr_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [49:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {ifc.imem_req, ifc.imem_addr, ifc.instr_out, ifc.target_out,
               ifc.link_addr, ifc.instr_valid, ifc.pc_out};
        n_tests++;
        if (got !== 50'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", got);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h00}) begin
            n_fail++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00", ifc.imem_req, ifc.imem_addr);
        end
    endtask

    task automatic test_backpressure;
        int cnt;
        wait_valid(cnt);
        n_tests++;
        if (cnt !== 2 || ifc.instr_out !== 8'h15) begin
            n_fail++; $display("FAIL bp_first_issue: got cnt=%0d instr=%h expected cnt=2 instr=15", cnt, ifc.instr_out);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if ({ifc.instr_valid, ifc.instr_out, ifc.imem_req} !== {1'b1, 8'h15, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold: got valid=%b instr=%h req=%b expected 1 15 0",
                                   ifc.instr_valid, ifc.instr_out, ifc.imem_req);
            end
        end
    endtask

    task automatic test_seq_fetch;
        logic [7:0] exp_i [3];
        int cnt;
        exp_i = '{8'h15, 8'h26, 8'h37};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                wait_valid(cnt);
                n_tests++;
                if (cnt !== 2) begin
                    n_fail++; $display("FAIL seq_latency: got %0d expected 2", cnt);
                end
            end
            n_tests++;
            if ({ifc.instr_valid, ifc.instr_out, ifc.target_out, ifc.link_addr, ifc.imem_addr} !==
                {1'b1, exp_i[i], 8'h00, 8'(i + 1), 8'(i)}) begin
                n_fail++; $display("FAIL seq_issue: got v=%b i=%h t=%h l=%h a=%h expected 1 %h 00 %h %h",
                    ifc.instr_valid, ifc.instr_out, ifc.target_out, ifc.link_addr, ifc.imem_addr,
                    exp_i[i], 8'(i + 1), 8'(i));
            end
            accept();
            n_tests++;
            if (ifc.pc_out !== 8'(i + 1)) begin
                n_fail++; $display("FAIL seq_pc: got %h expected %h", ifc.pc_out, 8'(i + 1));
            end
        end
    endtask

    task automatic test_jump;
        int cnt;
        wait_valid(cnt);
        accept();
        wait_valid(cnt);
        n_tests++;
        if ({cnt[7:0], ifc.instr_out, ifc.target_out, ifc.link_addr} !== {8'd4, 8'h80, 8'h20, 8'h06}) begin
            n_fail++; $display("FAIL j_issue: got cnt=%0d i=%h t=%h l=%h expected 4 80 20 06",
                               cnt, ifc.instr_out, ifc.target_out, ifc.link_addr);
        end
        accept();
        n_tests++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.pc_out} !== {1'b1, 8'h20, 8'h20}) begin
            n_fail++; $display("FAIL j_target: got req=%b addr=%h pc=%h expected 1 20 20",
                               ifc.imem_req, ifc.imem_addr, ifc.pc_out);
        end
        wait_valid(cnt);
        n_tests++;
        if ({ifc.instr_out, ifc.target_out, ifc.link_addr} !== {8'h90, 8'h40, 8'h22}) begin
            n_fail++; $display("FAIL jal_issue: got i=%h t=%h l=%h expected 90 40 22",
                               ifc.instr_out, ifc.target_out, ifc.link_addr);
        end
        accept();
        n_tests++;
        if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h40}) begin
            n_fail++; $display("FAIL jal_target: got req=%b addr=%h expected 1 40", ifc.imem_req, ifc.imem_addr);
        end
        wait_valid(cnt);
        accept();
    endtask

    task automatic test_branch;
        int cnt;
        wait_valid(cnt);
        n_tests++;
        if ({ifc.instr_out, ifc.target_out, ifc.link_addr} !== {8'hC1, 8'h30, 8'h0A}) begin
            n_fail++; $display("FAIL beq_issue: got i=%h t=%h l=%h expected C1 30 0A",
                               ifc.instr_out, ifc.target_out, ifc.link_addr);
        end
        ifc.br_valid = 1'b1; ifc.br_taken = 1'b1;
        @(negedge clk);
        ifc.br_valid = 1'b0;
        n_tests++;
        if ({ifc.instr_valid, ifc.pc_out, ifc.imem_req} !== {1'b1, 8'h08, 1'b0}) begin
            n_fail++; $display("FAIL br_in_issue: got v=%b pc=%h req=%b expected 1 08 0",
                               ifc.instr_valid, ifc.pc_out, ifc.imem_req);
        end
        ifc.instr_ready = 1'b1; ifc.br_valid = 1'b1; ifc.br_taken = 1'b0;
        @(negedge clk);
        ifc.instr_ready = 1'b0; ifc.br_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({ifc.imem_req, ifc.instr_valid, ifc.pc_out} !== {1'b0, 1'b0, 8'h08}) begin
                n_fail++; $display("FAIL br_wait: got req=%b v=%b pc=%h expected 0 0 08",
                                   ifc.imem_req, ifc.instr_valid, ifc.pc_out);
            end
            if (k < 2) @(negedge clk);
        end
        ifc.br_valid = 1'b1; ifc.br_taken = 1'b1;
        @(negedge clk);
        ifc.br_valid = 1'b0;
        n_tests++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.pc_out} !== {1'b1, 8'h30, 8'h30}) begin
            n_fail++; $display("FAIL br_taken: got req=%b addr=%h pc=%h expected 1 30 30",
                               ifc.imem_req, ifc.imem_addr, ifc.pc_out);
        end
        wait_valid(cnt);
        accept();
        wait_valid(cnt);
        accept();
        @(negedge clk);
        ifc.br_valid = 1'b1; ifc.br_taken = 1'b0;
        @(negedge clk);
        ifc.br_valid = 1'b0;
        n_tests++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.pc_out} !== {1'b1, 8'h0A, 8'h0A}) begin
            n_fail++; $display("FAIL br_not_taken: got req=%b addr=%h pc=%h expected 1 0A 0A",
                               ifc.imem_req, ifc.imem_addr, ifc.pc_out);
        end
    endtask

    task automatic test_reset_mid;
        logic [49:0] got;
        int cnt;
        man_en = 1'b1; man_rv = 1'b0; man_rd = 8'h91;
        rst_n = 1'b0;
        @(negedge clk);
        man_rv = 1'b1;
        @(negedge clk);
        man_rv = 1'b0;
        got = {ifc.imem_req, ifc.imem_addr, ifc.instr_out, ifc.target_out,
               ifc.link_addr, ifc.instr_valid, ifc.pc_out};
        n_tests++;
        if (got !== 50'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", got);
        end
        rst_n = 1'b1; man_rv = 1'b1;
        @(negedge clk);
        man_rv = 1'b0;
        n_tests++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.instr_valid, ifc.pc_out} !== {1'b1, 8'h00, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL mid_first_req: got req=%b addr=%h v=%b pc=%h expected 1 00 0 00",
                               ifc.imem_req, ifc.imem_addr, ifc.instr_valid, ifc.pc_out);
        end
        man_en = 1'b0;
        wait_valid(cnt);
        n_tests++;
        if ({ifc.instr_valid, ifc.instr_out} !== {1'b1, 8'h15}) begin
            n_fail++; $display("FAIL mid_refetch: got v=%b instr=%h expected 1 15", ifc.instr_valid, ifc.instr_out);
        end
    endtask

    task automatic test_wrap;
        int cnt;
        n_tests++;
        if ({ifc2.pc_out, ifc2.imem_req} !== {8'hFF, 1'b0}) begin
            n_fail++; $display("FAIL wrap_reset_pc: got pc=%h req=%b expected FF 0", ifc2.pc_out, ifc2.imem_req);
        end
        rst2_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ifc2.imem_req, ifc2.imem_addr} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL wrap_first_req: got req=%b addr=%h expected 1 FF", ifc2.imem_req, ifc2.imem_addr);
        end
        wait_valid2(cnt);
        n_tests++;
        if ({ifc2.instr_valid, ifc2.instr_out, ifc2.target_out, ifc2.link_addr} !== {1'b1, 8'h2A, 8'h00, 8'h00}) begin
            n_fail++; $display("FAIL wrap_1b_issue: got v=%b i=%h t=%h l=%h expected 1 2A 00 00",
                               ifc2.instr_valid, ifc2.instr_out, ifc2.target_out, ifc2.link_addr);
        end
        accept2();
        n_tests++;
        if ({ifc2.imem_req, ifc2.imem_addr, ifc2.pc_out} !== {1'b1, 8'h00, 8'h00}) begin
            n_fail++; $display("FAIL wrap_1b_next: got req=%b addr=%h pc=%h expected 1 00 00",
                               ifc2.imem_req, ifc2.imem_addr, ifc2.pc_out);
        end
        rst2_n = 1'b0;
        @(negedge clk);
        mem[8'hFF] = 8'h80; mem[8'h00] = 8'h55;
        rst2_n = 1'b1;
        @(negedge clk);
        wait_valid2(cnt);
        n_tests++;
        if ({ifc2.instr_valid, ifc2.instr_out, ifc2.target_out, ifc2.link_addr} !== {1'b1, 8'h80, 8'h55, 8'h01}) begin
            n_fail++; $display("FAIL wrap_2b_issue: got v=%b i=%h t=%h l=%h expected 1 80 55 01",
                               ifc2.instr_valid, ifc2.instr_out, ifc2.target_out, ifc2.link_addr);
        end
        accept2();
        n_tests++;
        if ({ifc2.imem_req, ifc2.imem_addr} !== {1'b1, 8'h55}) begin
            n_fail++; $display("FAIL wrap_2b_jump: got req=%b addr=%h expected 1 55", ifc2.imem_req, ifc2.imem_addr);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'h15; mem[8'h01] = 8'h26; mem[8'h02] = 8'h37; mem[8'h03] = 8'h00;
        mem[8'h04] = 8'h80; mem[8'h05] = 8'h20;
        mem[8'h08] = 8'hC1; mem[8'h09] = 8'h30;
        mem[8'h20] = 8'h90; mem[8'h21] = 8'h40;
        mem[8'h30] = 8'h80; mem[8'h31] = 8'h08;
        mem[8'h40] = 8'h80; mem[8'h41] = 8'h08;
        mem[8'hFF] = 8'h2A;
        man_en = 1'b0; man_rv = 1'b0; man_rd = 8'h00;
        rst_n = 1'b0; rst2_n = 1'b0;
        ifc.instr_ready = 1'b0;  ifc.br_valid = 1'b0;  ifc.br_taken = 1'b0;
        ifc2.instr_ready = 1'b0; ifc2.br_valid = 1'b0; ifc2.br_taken = 1'b0;

        test_reset();
        test_backpressure();
        test_seq_fetch();
        test_jump();
        test_branch();
        test_reset_mid();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
